// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin, burst-granular arbiter sharing one ready/valid sink among NUM_REQ requesters
//   clk, rst          : single clock, synchronous active-high reset
//   req_valid/data/last: per-requester stream inputs (slice i = requester i)
//   req_ready         : per-requester ready, at most one bit set
//   stream_in_*       : shared stream towards the datapath
//   grant_id, busy    : current/last granted requester, high while a grant is held
module stream_rr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int GW         = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW         = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          stream_in_valid,
    output logic [DATA_WIDTH-1:0]         stream_in_data,
    input  logic                          stream_in_ready,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d, last_q, last_d, pick;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_grant, xfer, done;
    assign in_grant        = (state_q == GRANT) && !rst;
    assign busy            = in_grant;
    assign grant_id        = grant_q;
    assign stream_in_valid = in_grant && req_valid[grant_q];
    assign stream_in_data  = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign req_ready       = in_grant ? (NUM_REQ'(stream_in_ready) << grant_q) : '0;
    assign xfer            = stream_in_valid && stream_in_ready;
    assign done            = req_last[grant_q] || (cnt_q == CW'(MAX_BURST - 1));
    // Scan from the lowest priority offset upward so the closest set bit after last_q wins.
    always_comb begin
        pick = last_q;
        for (int i = NUM_REQ; i >= 1; i--)
            if (req_valid[(int'(last_q) + i) % NUM_REQ])
                pick = GW'((int'(last_q) + i) % NUM_REQ);
    end
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (|req_valid) begin
                state_d = GRANT;
                grant_d = pick;
                cnt_d   = '0;
            end
        end else if (!req_valid[grant_q] || (xfer && done)) begin
            state_d = IDLE;
            last_d  = grant_q;
            cnt_d   = xfer ? cnt_q + CW'(1) : cnt_q;
        end else if (xfer) begin
            cnt_d = cnt_q + CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: scoreboard bench for stream_rr_arbiter with per-requester source queues
module tb_stream_rr_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [N*W-1:0] req_data;
    logic           stream_in_valid, stream_in_ready;
    logic [W-1:0]   stream_in_data;
    logic [1:0]     grant_id;
    logic           busy;
    logic [W:0]     mem [N][32];
    int             hd[N], tl[N];
    int             exp_q[$];
    int             bc[$];
    int             ncyc, vec, errs, k;
    logic           rst_v, rdy_v;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .stream_in_valid(stream_in_valid),
        .stream_in_data(stream_in_data), .stream_in_ready(stream_in_ready),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic load(input int i, input logic last, input logic [W-1:0] d);
        mem[i][tl[i]] = {last, d};
        tl[i]++;
    endtask

    task automatic expect_beat(input int id, input int d);
        exp_q.push_back(id * 256 + d);
    endtask

    // One clock: drive at negedge from the source queues, score any handshake, pop on posedge.
    task automatic cyc();
        logic [N-1:0] pop;
        int e;
        @(negedge clk);
        rst = rst_v;
        stream_in_ready = rdy_v;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = hd[i] != tl[i];
            req_data[i*W +: W] = mem[i][hd[i]][W-1:0];
            req_last[i]        = mem[i][hd[i]][W];
        end
        #1;
        if (rst) check("rst_quiet", {req_ready, stream_in_valid, busy}, 0);
        pop = '0;
        if (!rst && stream_in_valid && stream_in_ready) begin
            pop = req_valid & req_ready;
            bc.push_back(ncyc);
            if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                check("beat", {grant_id, stream_in_data}, e);
                check("ready_onehot", req_ready, 1 << (e >> 8));
            end
        end
        @(posedge clk);
        #1;
        ncyc++;
        for (int i = 0; i < N; i++) if (pop[i]) hd[i]++;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (exp_q.size() > 0 && n < max) begin
            cyc();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_v = 1'b1;
        cyc();
        cyc();
        rst_v = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rst_v = 1'b1; rdy_v = 1'b1; stream_in_ready = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0;
        vec = 0; errs = 0; ncyc = 0;
        for (int i = 0; i < N; i++) begin
            hd[i] = 0; tl[i] = 0;
            for (int j = 0; j < 32; j++) mem[i][j] = '0;
        end
        repeat (3) cyc();
        rst_v = 1'b0;
        cyc();
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        // single requester, 3-beat burst with last
        load(2, 0, 8'hA1); load(2, 0, 8'hA2); load(2, 1, 8'hA3);
        expect_beat(2, 'hA1); expect_beat(2, 'hA2); expect_beat(2, 'hA3);
        bc.delete();
        cyc();
        check("t1_busy", busy, 1);
        check("t1_grant_id", grant_id, 2);
        drain(10);
        check("t1_idle_after", busy, 0);
        check("t1_nbeats", bc.size(), 3);
        if (bc.size() == 3) check("t1_back_to_back", bc[2] - bc[0], 2);
        // all requesters with 1-beat bursts
        do_reset();
        load(0, 1, 8'h20); load(0, 1, 8'h21); load(1, 1, 8'h30); load(1, 1, 8'h31);
        load(2, 1, 8'h40); load(3, 1, 8'h50);
        expect_beat(0, 'h20); expect_beat(1, 'h30); expect_beat(2, 'h40);
        expect_beat(3, 'h50); expect_beat(0, 'h21); expect_beat(1, 'h31);
        bc.delete();
        drain(30);
        check("t2_nbeats", bc.size(), 6);
        if (bc.size() == 6) for (int i = 0; i < 5; i++) check("t2_gap", bc[i+1] - bc[i], 2);
        // MAX_BURST cut with a competing requester
        do_reset();
        for (int i = 0; i < 6; i++) load(1, 0, 8'(8'h10 + i));
        load(3, 1, 8'h30);
        for (int i = 0; i < 4; i++) expect_beat(1, 'h10 + i);
        expect_beat(3, 'h30); expect_beat(1, 'h14); expect_beat(1, 'h15);
        bc.delete();
        drain(40);
        cyc(); cyc();
        check("t3_idle_after", busy, 0);
        check("t3_nbeats", bc.size(), 7);
        if (bc.size() == 7) begin
            check("t3_burst", bc[3] - bc[0], 3);
            check("t3_gap_a", bc[4] - bc[3], 2);
            check("t3_gap_b", bc[5] - bc[4], 2);
        end
        // backpressure mid-burst
        for (int i = 0; i < 5; i++) load(0, 0, 8'(8'h60 + i));
        for (int i = 0; i < 5; i++) expect_beat(0, 'h60 + i);
        bc.delete();
        k = 0;
        while (bc.size() < 2 && k < 10) begin cyc(); k++; end
        check("t4_pre_stall", bc.size(), 2);
        rdy_v = 1'b0;
        repeat (5) begin
            cyc();
            check("t4_stall_ready", req_ready, 0);
            check("t4_stall_busy", busy, 1);
        end
        check("t4_frozen", bc.size(), 2);
        rdy_v = 1'b1;
        drain(20);
        check("t4_nbeats", bc.size(), 5);
        if (bc.size() == 5) begin
            check("t4_resume", bc[2] - bc[1], 6);
            check("t4_burst_tail", bc[3] - bc[2], 1);
            check("t4_burst_end", bc[4] - bc[3], 2);
        end
        cyc(); cyc();
        // abandon moves the pointer past requester 2
        load(2, 0, 8'h70);
        expect_beat(2, 'h70);
        drain(10);
        cyc();
        check("t5_abandon_idle", busy, 0);
        load(2, 1, 8'h71); load(3, 1, 8'h80);
        expect_beat(3, 'h80); expect_beat(2, 'h71);
        drain(20);
        cyc();
        // reset during the second beat of requester 1
        for (int i = 0; i < 4; i++) load(1, 0, 8'(8'h90 + i));
        expect_beat(1, 'h90);
        bc.delete();
        k = 0;
        while (bc.size() < 1 && k < 10) begin cyc(); k++; end
        check("t6_first_beat", bc.size(), 1);
        rst_v = 1'b1;
        load(0, 1, 8'hA0);
        cyc();
        rst_v = 1'b0;
        check("t6_rst_idle", busy, 0);
        check("t6_rst_grant_id", grant_id, 0);
        expect_beat(0, 'hA0); expect_beat(1, 'h91); expect_beat(1, 'h92); expect_beat(1, 'h93);
        drain(20);
        cyc(); cyc();
        check("t6_idle_after", busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one 8-bit ready/valid stream sink (the stream_in_* port of a downstream datapath block) among NUM_REQ upstream requesters.
- Round-robin, burst-granular arbitration. A grant is held until the requester signals last, MAX_BURST beats have been sent, or the requester abandons the burst.
- Sits between traffic generators and the datapath in the test designs. Grant and burst state are exposed for bench checking.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, stream data width in bits
MAX_BURST, 4, maximum beats per grant (1..255)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester valid, bit i = requester i
req_data  input  NUM_REQ*DATA_WIDTH  per-requester data, slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  per-requester end-of-burst marker, qualified by the beat transfer
req_ready  output  NUM_REQ  per-requester ready; at most one bit set
stream_in_valid  output  1  valid to datapath
stream_in_data  output  DATA_WIDTH  data to datapath
stream_in_ready  input  1  ready from datapath
grant_id  output  GW  index of current/last granted requester, GW = max(1, $clog2(NUM_REQ))
busy  output  1  high while in GRANT state

Behaviour:
- Reset (rst high at an edge):
  - State becomes IDLE; burst counter is 0; grant_id is 0.
  - Round-robin pointer last_grant becomes NUM_REQ-1, so requester 0 has top priority first.
  - While rst is high, req_ready, stream_in_valid and busy are forced 0 combinationally.
  - No beat is transferred in a cycle where rst is high.
- Transfer: a beat transfers in a cycle when stream_in_valid && stream_in_ready, in GRANT state only.
- IDLE state:
  - All req_ready are 0 and stream_in_valid is 0.
  - If any req_valid is set, select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register the selection into grant_id, clear the burst counter, and go to GRANT on the next edge.
  - Arbitration latency is 1 cycle: a request seen in IDLE at edge n has its first possible transfer at edge n+1.
- GRANT state, with g = grant_id:
  - Purely combinational pass-through: stream_in_valid = req_valid[g]; stream_in_data = req_data slice g; req_ready[g] = stream_in_ready; all other req_ready bits are 0.
  - On a transfer, increment the burst counter.
  - If that transfer has req_last[g] = 1, or the counter was MAX_BURST-1 before increment: go to IDLE and set last_grant = g.
  - Abandon: if req_valid[g] = 0 in a GRANT cycle, go to IDLE and set last_grant = g. Beats already sent stand.
  - Otherwise stay in GRANT.
  - stream_in_ready low holds state: no counter change, and data/valid follow the requester (the requester must hold them stable).
- Throughput:
  - At least one IDLE cycle separates consecutive grants.
  - Within a grant, one beat per cycle while both sides are ready.
- Simultaneous events:
  - req_last together with MAX_BURST reached ends the burst once; there is no double pointer update.
  - Requests arriving in GRANT state are ignored until the next IDLE.
  - grant_id holds its last value in IDLE, except that a new arbitration overwrites it.
- The counter width is ceil(log2(MAX_BURST+1)). It never exceeds MAX_BURST-1 in GRANT.
- Reset mid-burst: the grant is dropped immediately and the next grant starts from requester 0 priority. Data is not replayed.

Test Plan:
- Single requester: req 2 sends 3 beats 0xA1,0xA2,0xA3 with last on 0xA3, ready=1. Expected: grant_id=2 and busy one cycle after request; stream_in_data A1,A2,A3 on consecutive cycles; IDLE after A3.
- All 4 requesters continuously valid, each sending 1-beat bursts with last=1. Expected grant order: 0,1,2,3,0,1; each beat separated by exactly one IDLE cycle.
- MAX_BURST=4: req 1 valid with 6 beats 0x10..0x15, no last, req 3 also valid. Expected: 0x10..0x13 sent, then req 3 granted, then req 1 resumes with 0x14.
- Backpressure: req 0 in GRANT, stream_in_ready low for 5 cycles mid-burst. Expected: no transfers and counter frozen; req_ready[0]=0 during the stall; burst still ends after the MAX_BURST total beats.
- Abandon: req 2 granted sends 1 beat, then deasserts valid. Expected: IDLE next cycle with last_grant=2; if req 2 and req 3 both then request, req 3 is granted first.
- Reset mid-burst: rst=1 for 1 cycle during req 1's 2nd beat. Expected: req_ready all 0 and stream_in_valid=0 in that cycle; IDLE after; with reqs 1 and 0 both valid, req 0 is granted.
